matrix_mac_stream: RTL and testbench

//  Parametrised NxN signed matrix multiply-accumulate engine: C += A*B, built up as K outer products.

---
 rtl/matrix_mac_pkg.sv | 52 +++++
 rtl/matrix_mac_stream_if.sv | 31 +++
 rtl/matrix_mac_cell.sv | 55 +++++
 rtl/matrix_mac_stream.sv | 121 ++++++++++++
 tb/tb_matrix_mac_stream.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_mac_pkg.sv
// Shared FSM encoding, result type and arithmetic helpers for the matrix MAC engine.
// Latency: none (constants, types and pure functions only).
// Backpressure: none.
package matrix_mac_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        FLUSH = ST_FLUSH,
        DRAIN = ST_DRAIN
    } state_t;

    // Accumulate result: value is exact when saturating, otherwise the caller
    // truncates to its accumulator width, which yields two's-complement wrap.
    typedef struct packed {
        logic        ovf;
        logic [63:0] val;
    } sat_res_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    // Operands arrive already sign-extended to 64 bits; accumulators up to
    // 62 bits wide cannot overflow the 64-bit intermediate sum.
    function automatic sat_res_t sat_add(input longint acc, input longint prod,
                                         input int acc_w, input bit sat);
        longint   sum;
        longint   hi;
        longint   lo;
        sat_res_t r;
        sum   = acc + prod;
        hi    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (sum > hi) || (sum < lo);
        r.val = sum;
        if (sat && (sum > hi)) r.val = hi;
        else if (sat && (sum < lo)) r.val = lo;
        return r;
    endfunction

endpackage

// File: rtl/matrix_mac_stream_if.sv
// Operand-beat and result-row handshake bundle for the matrix MAC engine.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready and out_valid/out_ready valid-ready pairs.
interface matrix_mac_stream_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
);
    localparam int IDX_W = matrix_mac_pkg::clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_col_a;
    logic [N*DATA_WIDTH-1:0] in_row_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*ACC_WIDTH-1:0]  out_row;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;

    modport master (
        output in_valid, in_col_a, in_row_b, out_ready,
        input  in_ready, out_valid, out_row, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_col_a, in_row_b, out_ready,
        output in_ready, out_valid, out_row, out_idx, out_last
    );

endinterface

// File: rtl/matrix_mac_cell.sv
// One (i,j) cell: registers a*b, then adds it into a saturating/wrapping accumulator.
// Latency: 2 cycles from en to acc.
// Backpressure: none; clr discards the pending product and zeroes acc.
module matrix_mac_cell
    import matrix_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int SATURATE   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc,
    output logic                        ovf
);

    logic signed [2*DATA_WIDTH-1:0] prod_q;
    logic                           prod_vld;
    sat_res_t                       sum;
    logic                           unused_hi;

    // Next accumulator value for the product currently held in stage 1.
    always_comb begin
        sum = sat_add(longint'(acc), longint'(prod_q), ACC_WIDTH, SATURATE != 0);
    end

    // Overflow is reported only on a cycle that actually retires a product.
    assign ovf       = prod_vld && sum.ovf;
    assign unused_hi = ^sum.val[63:ACC_WIDTH];

    // Stage 1: capture the full-precision signed product.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= en;
            if (en) prod_q <= (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        end
    end

    // Stage 2: fold the product into the accumulator.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (prod_vld) begin
            acc <= sum.val[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/matrix_mac_stream.sv
// NxN outer-product MAC (C += a*b^T per beat) with row-by-row result drain.
// Latency: beat visible in acc 2 cycles after accept; first row 2 cycles after drain.
// Backpressure: in_ready low in FLUSH/DRAIN and during clear; rows held while out_ready low.
module matrix_mac_stream
    import matrix_mac_pkg::*;
#(
    parameter int N              = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 20,
    parameter int SATURATE       = 1,
    parameter int CLEAR_ON_DRAIN = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                drain,
    matrix_mac_stream_if.slave  bus,
    output logic                busy,
    output logic                overflow
);

    localparam int IDX_W = clog2(N);

    state_t                      state_q;
    state_t                      state_d;
    logic [IDX_W-1:0]            idx_q;
    logic                        idle_or_accum;
    logic                        accept;
    logic                        row_done;
    logic                        zero_acc;
    logic                        ovf_clr;
    logic signed [ACC_WIDTH-1:0] acc_w [N][N];
    logic [N*N-1:0]              cell_ovf;

    assign idle_or_accum = (state_q == IDLE) || (state_q == ACCUM);
    assign bus.in_ready  = idle_or_accum && !clear && !reset;
    assign accept        = bus.in_valid && bus.in_ready;
    assign row_done      = (state_q == DRAIN) && bus.out_ready && (idx_q == IDX_W'(N - 1));

    assign busy          = (state_q != IDLE);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (state_q == DRAIN) && (idx_q == IDX_W'(N - 1));

    // Next-state logic; clear outranks drain, drain outranks a plain beat.
    always_comb begin
        state_d  = state_q;
        zero_acc = 1'b0;
        ovf_clr  = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (clear) begin
                    state_d  = IDLE;
                    zero_acc = 1'b1;
                    ovf_clr  = 1'b1;
                end else if (drain) begin
                    state_d = FLUSH;
                end else if (accept) begin
                    state_d = ACCUM;
                end
            end
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (row_done) begin
                    state_d  = (CLEAR_ON_DRAIN != 0) ? IDLE : ACCUM;
                    zero_acc = (CLEAR_ON_DRAIN != 0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Row index advances on each accepted result row and wraps after the last.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
        end else if ((state_q == DRAIN) && bus.out_ready) begin
            idx_q <= row_done ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Sticky overflow; the drain-end accumulator zeroing deliberately leaves it set.
    always_ff @(posedge clock) begin
        if (reset || ovf_clr) overflow <= 1'b0;
        else if (|cell_ovf)   overflow <= 1'b1;
    end

    // Select the accumulator row addressed by the drain index.
    always_comb begin
        bus.out_row = '0;
        for (int j = 0; j < N; j++) begin
            bus.out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[idx_q][j];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            matrix_mac_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SATURATE   (SATURATE)
            ) u_cell (
                .clock (clock),
                .reset (reset),
                .clr   (zero_acc),
                .en    (accept),
                .a     (bus.in_col_a[i*DATA_WIDTH +: DATA_WIDTH]),
                .b     (bus.in_row_b[j*DATA_WIDTH +: DATA_WIDTH]),
                .acc   (acc_w[i][j]),
                .ovf   (cell_ovf[i*N + j])
            );
        end
    end

endmodule

// File: tb/tb_matrix_mac_stream.sv
// Three engines (saturate/clear, wrap/clear, saturate/keep) driven in lockstep.
// Latency: n/a.
// Backpressure: random and scripted out_ready stalls.
module tb_matrix_mac_stream;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam longint HI  = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint LO  = -HI - 1;
    localparam longint MOD = longint'(1) <<< AW;

    typedef struct packed {
        logic [2:0][N*AW-1:0] rows;
        logic [1:0]           idx;
    } exp_t;

    logic clock;
    logic reset, clear, drain, in_valid, out_ready;
    logic [N*DW-1:0] in_col_a, in_row_b;

    logic [2:0]             ov, olast, ordy, obusy, oovf;
    logic [2:0][N*AW-1:0]   orow;
    logic [2:0][1:0]        oidx;

    int checks = 0;
    int errors = 0;

    longint macc [3][N][N];
    bit     movf [3];
    exp_t   expq [$];
    exp_t   cur;

    matrix_mac_stream_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) b0 ();
    matrix_mac_stream_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) b1 ();
    matrix_mac_stream_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) b2 ();

    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;  assign b2.in_valid = in_valid;
    assign b0.in_col_a = in_col_a;  assign b1.in_col_a = in_col_a;  assign b2.in_col_a = in_col_a;
    assign b0.in_row_b = in_row_b;  assign b1.in_row_b = in_row_b;  assign b2.in_row_b = in_row_b;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready; assign b2.out_ready = out_ready;

    assign ov    = {b2.out_valid, b1.out_valid, b0.out_valid};
    assign olast = {b2.out_last,  b1.out_last,  b0.out_last};
    assign ordy  = {b2.in_ready,  b1.in_ready,  b0.in_ready};
    assign orow  = {b2.out_row,   b1.out_row,   b0.out_row};
    assign oidx  = {b2.out_idx,   b1.out_idx,   b0.out_idx};

    matrix_mac_stream #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1), .CLEAR_ON_DRAIN(1)) dut_sat (
        .clock(clock), .reset(reset), .clear(clear), .drain(drain), .bus(b0.slave),
        .busy(obusy[0]), .overflow(oovf[0]));
    matrix_mac_stream #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0), .CLEAR_ON_DRAIN(1)) dut_wrap (
        .clock(clock), .reset(reset), .clear(clear), .drain(drain), .bus(b1.slave),
        .busy(obusy[1]), .overflow(oovf[1]));
    matrix_mac_stream #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1), .CLEAR_ON_DRAIN(0)) dut_keep (
        .clock(clock), .reset(reset), .clear(clear), .drain(drain), .bus(b2.slave),
        .busy(obusy[2]), .overflow(oovf[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_row(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        for (int v = 0; v < 3; v++) begin
            movf[v] = 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) macc[v][i][j] = 0;
        end
        expq.delete();
    endtask

    task automatic model_clear();
        for (int v = 0; v < 3; v++) begin
            movf[v] = 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) macc[v][i][j] = 0;
        end
    endtask

    // Variant 0 and 2 clamp, variant 1 wraps modulo 2^AW.
    task automatic model_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        longint s;
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    s = macc[v][i][j] + longint'($signed(a[i*DW +: DW])) * longint'($signed(b[j*DW +: DW]));
                    if (s > HI || s < LO) begin
                        movf[v] = 1'b1;
                        if (v == 1) s = ((s - LO) % MOD + MOD) % MOD + LO;
                        else        s = (s > HI) ? HI : LO;
                    end
                    macc[v][i][j] = s;
                end
    endtask

    task automatic model_drain();
        exp_t   e;
        longint t;
        for (int i = 0; i < N; i++) begin
            e = '0;
            e.idx = 2'(i);
            for (int v = 0; v < 3; v++)
                for (int j = 0; j < N; j++) begin
                    t = macc[v][i][j];
                    e.rows[v][j*AW +: AW] = t[AW-1:0];
                end
            expq.push_back(e);
        end
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) macc[v][i][j] = 0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (!reset && (|ov)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: out_valid=%b with no row expected", ov);
            end else begin
                cur = expq[0];
                for (int v = 0; v < 3; v++) begin
                    chk($sformatf("out_valid[%0d]", v), ov[v], 1);
                    chk_row($sformatf("out_row[%0d] idx%0d", v, cur.idx), orow[v], cur.rows[v]);
                    chk($sformatf("out_idx[%0d]", v), oidx[v], cur.idx);
                    chk($sformatf("out_last[%0d]", v), olast[v], cur.idx == 2'd3);
                end
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input bit with_drain);
        in_valid = 1'b1;
        in_col_a = a;
        in_row_b = b;
        drain    = with_drain;
        #1;
        for (int v = 0; v < 3; v++) chk($sformatf("in_ready_beat[%0d]", v), ordy[v], 1);
        model_beat(a, b);
        if (with_drain) model_drain();
        tick();
        in_valid = 1'b0;
        drain    = 1'b0;
    endtask

    task automatic start_drain();
        drain = 1'b1;
        model_drain();
        tick();
        drain = 1'b0;
    endtask

    // mode 0: ready except a 3-cycle stall on row 1; mode 1: random ready.
    task automatic run_drain(input int mode);
        int cyc;
        int stall;
        cyc   = 0;
        stall = 0;
        while (expq.size() > 0 && cyc < 200) begin
            if (mode == 0) begin
                if (ov[0] && expq.size() == 3 && stall < 3) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_rows_outstanding", expq.size(), 0);
        expq.delete();
    endtask

    task automatic post_drain_checks(input string tag);
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("%s busy[%0d]", tag, v), obusy[v], (v == 2));
            chk($sformatf("%s overflow[%0d]", tag, v), oovf[v], movf[v]);
            chk($sformatf("%s out_valid_after[%0d]", tag, v), ov[v], 0);
        end
    endtask

    task automatic identity_run();
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) a[i*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
            for (int j = 0; j < N; j++) b[j*DW +: DW] = 8'(k*4 + j - 8);
            beat(a, b, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        reset = 1'b1; clear = 1'b0; drain = 1'b0; in_valid = 1'b0;
        in_col_a = '0; in_row_b = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("rst in_ready[%0d]", v), ordy[v], 0);
            chk($sformatf("rst out_valid[%0d]", v), ov[v], 0);
            chk($sformatf("rst busy[%0d]", v), obusy[v], 0);
            chk($sformatf("rst overflow[%0d]", v), oovf[v], 0);
            chk($sformatf("rst out_idx[%0d]", v), oidx[v], 0);
            chk($sformatf("rst out_last[%0d]", v), olast[v], 0);
        end
        reset = 1'b0;
        #1;
        for (int v = 0; v < 3; v++) chk($sformatf("idle in_ready[%0d]", v), ordy[v], 1);

        // Identity run with a scripted stall on row 1.
        identity_run();
        chk("model B00", macc[0][0][0], -8);
        chk("model B12", macc[0][1][2], -2);
        chk("model B33", macc[0][3][3], 7);
        start_drain();
        run_drain(0);
        post_drain_checks("ident1");

        // Second identity run: keep-variant must hold 2*B.
        identity_run();
        chk("model keep 2B33", macc[2][3][3], 14);
        chk("model keep 2B00", macc[2][0][0], -16);
        start_drain();
        run_drain(1);
        post_drain_checks("ident2");

        // Random beats, last one accepted together with drain.
        k = $urandom_range(3, 8);
        for (int n = 0; n < k; n++) begin
            beat($urandom, $urandom, n == k - 1);
            if (n != k - 1) repeat ($urandom_range(0, 2)) tick();
        end
        run_drain(1);
        post_drain_checks("random");

        // Pending product, then clear with in_valid and drain in the same cycle.
        beat($urandom, $urandom, 1'b0);
        clear = 1'b1; in_valid = 1'b1; drain = 1'b1;
        in_col_a = $urandom; in_row_b = $urandom;
        #1;
        for (int v = 0; v < 3; v++) chk($sformatf("clear in_ready[%0d]", v), ordy[v], 0);
        model_clear();
        tick();
        clear = 1'b0; in_valid = 1'b0; drain = 1'b0;
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("clear busy[%0d]", v), obusy[v], 0);
            chk($sformatf("clear overflow[%0d]", v), oovf[v], 0);
        end
        start_drain();
        run_drain(1);
        post_drain_checks("clear");

        // Saturation vs wrap: 32 beats of -128 * -128.
        for (int n = 0; n < 32; n++) beat({N{8'h80}}, {N{8'h80}}, 1'b0);
        chk("model sat", macc[0][0][0], 524287);
        chk("model wrap", macc[1][2][3], -524288);
        chk("model keep sat", macc[2][1][1], 524287);
        chk("model ovf", movf[1], 1);
        start_drain();
        run_drain(1);
        post_drain_checks("sat");
        clear = 1'b1;
        model_clear();
        tick();
        clear = 1'b0;
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("ovf_clear overflow[%0d]", v), oovf[v], 0);
            chk($sformatf("ovf_clear busy[%0d]", v), obusy[v], 0);
        end

        // Reset in the middle of a drain, after row 1 has been taken.
        beat($urandom, $urandom, 1'b0);
        beat($urandom, $urandom, 1'b0);
        start_drain();
        out_ready = 1'b1;
        k = 0;
        while (expq.size() > 2 && k < 50) begin
            tick();
            k++;
        end
        chk("midreset rows_taken", expq.size(), 2);
        reset = 1'b1;
        model_reset();
        tick();
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("midreset out_valid[%0d]", v), ov[v], 0);
            chk($sformatf("midreset busy[%0d]", v), obusy[v], 0);
            chk($sformatf("midreset out_idx[%0d]", v), oidx[v], 0);
        end
        reset = 1'b0;
        beat({N{8'h01}}, {N{8'h01}}, 1'b0);
        chk("model ones", macc[0][2][1], 1);
        start_drain();
        run_drain(1);
        post_drain_checks("ones");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
